// File: rtl/err_ovld_frm_gen.sv
// Error/overload frame generator.
// Builds the active/passive error flag or the overload flag, waits for a recessive
// bus, then sends the delimiter. Feeds the serialized-frame transmit mux with the
// err/ovld bit and the frame-type qualifiers. All outputs come straight from flops.
// FLAG_LEN and DELIM_LEN must be in 2..15 (4-bit saturating counters).
module err_ovld_frm_gen #(
    parameter int unsigned FLAG_LEN  = 6,
    parameter int unsigned DELIM_LEN = 8
) (
    input  logic i_clk,
    input  logic i_g_rst,
    input  logic i_bit_en,
    input  logic i_err_det,
    input  logic i_ovld_req,
    input  logic i_err_psv,
    input  logic i_bus_off_sts,
    input  logic i_can_bus_in,
    output logic o_err_ovld_out,
    output logic o_act_err_frm_tx,
    output logic o_psv_err_frm_tx,
    output logic o_ovld_frm_tx,
    output logic o_dom_after_flag,
    output logic o_bit_err,
    output logic o_frm_done
);

    localparam logic [3:0] FLAG_LEN_C  = 4'(FLAG_LEN);
    localparam logic [3:0] DELIM_LEN_C = 4'(DELIM_LEN);

    typedef enum logic [1:0] {
        StIdle,
        StFlag,
        StWaitRec,
        StDelim
    } state_t;

    // Registered state and outputs
    state_t     r_state;
    logic       r_act;
    logic       r_psv;
    logic       r_ovld;
    logic [3:0] r_bit_cnt;
    logic [3:0] r_eq_cnt;
    logic       r_prev_bus;
    logic       r_dom_seen;
    logic       r_out;
    logic       r_dom_pulse;
    logic       r_bit_err;
    logic       r_frm_done;

    // Next-state values
    state_t     w_state;
    logic       w_act;
    logic       w_psv;
    logic       w_ovld;
    logic [3:0] w_bit_cnt;
    logic [3:0] w_eq_cnt;
    logic       w_prev_bus;
    logic       w_dom_seen;
    logic       w_out;
    logic       w_dom_pulse;
    logic       w_bit_err;
    logic       w_frm_done;

    // Frame (re)start request built up by the state decode
    logic       w_start;
    logic       w_start_ovld;
    logic       w_start_psv;

    logic [3:0] w_bit_inc;
    logic [3:0] w_eq_nxt;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Next-state, counter and output decode
    always_comb begin
        w_state      = r_state;
        w_act        = r_act;
        w_psv        = r_psv;
        w_ovld       = r_ovld;
        w_bit_cnt    = r_bit_cnt;
        w_eq_cnt     = r_eq_cnt;
        w_prev_bus   = r_prev_bus;
        w_dom_seen   = r_dom_seen;
        w_out        = r_out;
        w_dom_pulse  = 1'b0;
        w_bit_err    = 1'b0;
        w_frm_done   = 1'b0;
        w_start      = 1'b0;
        w_start_ovld = 1'b0;
        w_start_psv  = 1'b0;
        w_bit_inc    = sat_inc(r_bit_cnt);
        // eq_cnt of 0 means no bus bit seen yet in this passive flag
        w_eq_nxt     = ((r_eq_cnt == 4'd0) || (i_can_bus_in != r_prev_bus)) ?
                       4'd1 : sat_inc(r_eq_cnt);

        if (i_bus_off_sts) begin
            // Bus-off abandons any frame immediately, independent of bit_en
            w_state    = StIdle;
            w_act      = 1'b0;
            w_psv      = 1'b0;
            w_ovld     = 1'b0;
            w_bit_cnt  = 4'd0;
            w_eq_cnt   = 4'd0;
            w_prev_bus = 1'b0;
            w_dom_seen = 1'b0;
            w_out      = 1'b1;
        end else if (i_bit_en) begin
            unique case (r_state)
                StIdle: begin
                    if (i_err_det) begin
                        w_start     = 1'b1;
                        w_start_psv = i_err_psv;
                    end else if (i_ovld_req) begin
                        w_start      = 1'b1;
                        w_start_ovld = 1'b1;
                    end
                end

                StFlag: begin
                    w_bit_cnt = w_bit_inc;
                    if (r_psv) begin
                        // Passive flag ends after FLAG_LEN equal bus bits
                        w_eq_cnt   = w_eq_nxt;
                        w_prev_bus = i_can_bus_in;
                        if (w_eq_nxt == FLAG_LEN_C) begin
                            w_state = StWaitRec;
                            w_out   = 1'b1;
                        end
                    end else begin
                        // Recessive bus under our dominant bit; flag is not restarted
                        if (i_can_bus_in) begin
                            w_bit_err = 1'b1;
                        end
                        if (w_bit_inc == FLAG_LEN_C) begin
                            w_state = StWaitRec;
                            w_out   = 1'b1;
                        end
                    end
                end

                StWaitRec: begin
                    if (!i_can_bus_in) begin
                        if (!r_dom_seen) begin
                            w_dom_pulse = 1'b1;
                            w_dom_seen  = 1'b1;
                        end
                    end else begin
                        // This recessive bit is delimiter bit 1
                        w_bit_cnt = 4'd1;
                        w_state   = StDelim;
                    end
                end

                StDelim: begin
                    // The bit on the bus now is delimiter bit r_bit_cnt+1
                    if (i_can_bus_in) begin
                        w_bit_cnt = w_bit_inc;
                        if (w_bit_inc == DELIM_LEN_C) begin
                            w_state    = StIdle;
                            w_act      = 1'b0;
                            w_psv      = 1'b0;
                            w_ovld     = 1'b0;
                            w_frm_done = 1'b1;
                        end
                    end else if (w_bit_inc == DELIM_LEN_C) begin
                        w_start      = 1'b1;
                        w_start_ovld = 1'b1;
                    end else begin
                        w_bit_err   = 1'b1;
                        w_start     = 1'b1;
                        w_start_psv = i_err_psv;
                    end
                end

                default: begin
                    w_state = StIdle;
                    w_act   = 1'b0;
                    w_psv   = 1'b0;
                    w_ovld  = 1'b0;
                    w_out   = 1'b1;
                end
            endcase

            if (w_start) begin
                w_state    = StFlag;
                w_act      = !w_start_ovld && !w_start_psv;
                w_psv      = !w_start_ovld && w_start_psv;
                w_ovld     = w_start_ovld;
                w_bit_cnt  = 4'd0;
                w_eq_cnt   = 4'd0;
                w_dom_seen = 1'b0;
                // Passive flag is recessive; active and overload flags are dominant
                w_out      = !w_start_ovld && w_start_psv;
            end
        end
    end

    // State, counter and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_g_rst) begin
            r_state     <= StIdle;
            r_act       <= 1'b0;
            r_psv       <= 1'b0;
            r_ovld      <= 1'b0;
            r_bit_cnt   <= 4'd0;
            r_eq_cnt    <= 4'd0;
            r_prev_bus  <= 1'b0;
            r_dom_seen  <= 1'b0;
            r_out       <= 1'b1;
            r_dom_pulse <= 1'b0;
            r_bit_err   <= 1'b0;
            r_frm_done  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_act       <= w_act;
            r_psv       <= w_psv;
            r_ovld      <= w_ovld;
            r_bit_cnt   <= w_bit_cnt;
            r_eq_cnt    <= w_eq_cnt;
            r_prev_bus  <= w_prev_bus;
            r_dom_seen  <= w_dom_seen;
            r_out       <= w_out;
            r_dom_pulse <= w_dom_pulse;
            r_bit_err   <= w_bit_err;
            r_frm_done  <= w_frm_done;
        end
    end

    assign o_err_ovld_out   = r_out;
    assign o_act_err_frm_tx = r_act;
    assign o_psv_err_frm_tx = r_psv;
    assign o_ovld_frm_tx    = r_ovld;
    assign o_dom_after_flag = r_dom_pulse;
    assign o_bit_err        = r_bit_err;
    assign o_frm_done       = r_frm_done;

endmodule
